apb_pwm_multi: RTL and testbench
================================

Name: apb_pwm_multi

Overview:
- Multi-channel APB3 slave PWM generator; successor to the single-channel APB PWM block.
- NUM_CH independent channels, each with its own counter, period and duty.
- Double-buffered (shadow) period/duty, applied only at period boundaries, so outputs never glitch.
- Per-channel output polarity and a period-wrap interrupt with sticky W1C status; sits on the peripheral APB bus next to the existing timer blocks.

Parameters:
- NUM_CH, 4, number of PWM channels (1..16).
- CNT_W, 16, counter/period/duty width in bits (2..32).
- ADDR_W, 12, PADDR width.
- DATA_W, 32, PWDATA/PRDATA width; fixed at 32.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PADDR  in  ADDR_W  byte address.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  DATA_W  write data.
- PREADY  out  1  tied 1; zero wait states.
- PSLVERR  out  1  error response, valid in access phase.
- PRDATA  out  DATA_W  read data; combinational, valid when PSEL&PENABLE&!PWRITE, else 0.
- pwm_out  out  NUM_CH  registered PWM outputs, bit n = channel n.
- irq  out  1  registered, |(STATUS & IRQ_EN).

Behaviour:
- Reset is asynchronous and active-low on PRESETn; single clock PCLK.
- Reset state: all registers, counters, pwm_out and irq are 0; PSLVERR is 0.
- Transfer:
  - A transfer occurs when PSEL&PENABLE.
  - Writes commit at that edge.
  - Addresses are aligned; PADDR[1:0]!=0 is an error.
- Global register map:
  - 0x000 CTRL, RW: bit0 GEN, global enable.
  - 0x004 STATUS, RW1C: bit n = channel n wrap flag.
  - 0x008 IRQ_EN, RW: bit n.
- Per-channel register map, base 0x100+n*0x10:
  - +0x0 PERIOD, RW, pending value.
  - +0x4 DUTY, RW, pending value.
  - +0x8 CFG, RW: bit0 EN, bit1 POL.
  - +0xC CNT, RO: active counter value.
  - Reads of PERIOD/DUTY return the pending value. Unused bits read 0 and are ignored on write.
- PSLVERR=1 on:
  - unmapped address;
  - channel index >= NUM_CH;
  - write to CNT;
  - misaligned address.
  - An errored write changes no state. An errored read returns PRDATA=0.
- Channel n runs iff GEN & CFG[n].EN ("run").
- Activation (run 0->1 at an edge):
  - cnt<=0;
  - per_act<=PERIOD;
  - duty_act<=DUTY.
- While running, each cycle:
  - If cnt==per_act: cnt<=0; per_act<=PERIOD and duty_act<=DUTY (pending values sampled pre-write if written the same edge); STATUS[n]<=1.
  - Otherwise cnt<=cnt+1.
  - Period length = per_act+1 cycles.
- Output while running: pwm_out[n]<=(cnt<duty_act)^POL. Output is registered, so it lags cnt by one cycle.
  - duty_act=0 gives constant POL.
  - duty_act>per_act gives constant !POL, i.e. 100%.
- Stopped (run=0):
  - cnt<=0;
  - pwm_out[n]<=POL (idle level);
  - active registers hold;
  - no wrap flags.
- per_act=0: cnt stays 0 and a wrap occurs every cycle; STATUS[n] is set each cycle.
- STATUS W1C: a write of 1 clears the bit. A wrap on the same edge wins (bit stays 1).
- POL change applies at the next edge regardless of boundary, whether running or stopped.
- PERIOD/DUTY writes never affect the current period.
- irq updates one edge after STATUS/IRQ_EN change.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); outputs go 0 regardless of POL until released.

Test Plan:
- Reset/register read-back:
  - Stimulus: after reset, read every register; write 0xFFFFFFFF to ch0 PERIOD/DUTY/CFG with CNT_W=16.
  - Required response: reset reads are 0; read-back is 0xFFFF, 0xFFFF, 0x3; PSLVERR=0 throughout.
- Basic waveform:
  - Stimulus: ch1 PERIOD=9, DUTY=3, POL=0, then EN=1, GEN=1.
  - Required response: pwm_out[1] repeats 3 high / 7 low; STATUS[1] sets every 10 cycles; with IRQ_EN[1]=1, irq=1 one cycle after the first wrap.
- Shadow update:
  - Stimulus: while ch1 runs at cnt=4, write DUTY=7.
  - Required response: the current period keeps 3 high cycles; the next period is 7 high / 3 low; writing DUTY on the exact wrap edge takes effect one period later.
- Edge duty values and polarity:
  - Stimulus: DUTY=0, then DUTY=12 with PERIOD=9, then POL=1.
  - Required response: pwm_out constant 0, then constant 1, then inverted; disabling EN with POL=1 gives idle 1.
- Error responses:
  - Stimulus: access 0x040; with NUM_CH=4 access ch4 base 0x140; write ch0 CNT; access 0x102.
  - Required response: PSLVERR=1 on each; no register changes; reads return 0.
- W1C collision and async reset:
  - Stimulus: W1C STATUS on the same edge as a wrap; then assert PRESETn low mid-period for a partial cycle.
  - Required response: the status bit stays 1 after the collision; pwm_out, irq and CNT go 0 asynchronously on reset, and GEN=0 after release.

Source files
------------

// File: rtl/apb_pwm_multi_if.sv
// APB3 bus bundle for the multi-channel PWM block.
// The requester side drives address, control and write data. The completer side returns the
// ready, error and read-data responses.
interface apb_pwm_multi_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) ();
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PREADY, PSLVERR, PRDATA
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PREADY, PSLVERR, PRDATA
    );
endinterface

// File: rtl/apb_pwm_multi.sv
// Multi-channel PWM generator with an APB3 register interface.
// Each channel has its own counter and shadowed period/duty registers. A pending period or duty
// value becomes active only at a period boundary, so the output never glitches. Each channel
// sets a sticky wrap flag in STATUS, and irq is driven from the flags enabled in IRQ_EN.
module apb_pwm_multi #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_pwm_multi_if.slave    apb,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    // Channel registers occupy the address page 0x100..0x1FF.
    localparam logic [ADDR_W-9:0] ChPage = (ADDR_W-8)'(1);

    logic              access, wr_en, err, misaligned, is_glb, ch_ok;
    logic [3:0]        ch_idx;
    logic [1:0]        reg_sel;
    logic              wr_ctrl, wr_status, wr_irq_en;
    logic [NUM_CH-1:0] wr_per, wr_duty, wr_cfg;

    logic              gen_q, gen_d, irq_q;
    logic [NUM_CH-1:0] status_q, irq_en_q, en_q, en_d, pol_q, pwm_q;
    logic [NUM_CH-1:0] run_q, run_d, wrap;
    logic [CNT_W-1:0]  period_q   [NUM_CH];
    logic [CNT_W-1:0]  duty_q     [NUM_CH];
    logic [CNT_W-1:0]  cnt_q      [NUM_CH];
    logic [CNT_W-1:0]  per_act_q  [NUM_CH];
    logic [CNT_W-1:0]  duty_act_q [NUM_CH];
    logic [DATA_W-1:0] rdata;

    // Decode the address and flag errors: misaligned, unmapped, missing channel, or a CNT write.
    always_comb begin
        misaligned = |apb.PADDR[1:0];
        ch_idx     = apb.PADDR[7:4];
        reg_sel    = apb.PADDR[3:2];
        is_glb     = (apb.PADDR[ADDR_W-1:4] == '0) && (reg_sel != 2'd3);
        ch_ok      = (apb.PADDR[ADDR_W-1:8] == ChPage) && (32'(ch_idx) < NUM_CH);
        err        = misaligned || !(is_glb || ch_ok) ||
                     (ch_ok && (reg_sel == 2'd3) && apb.PWRITE);
        access     = apb.PSEL & apb.PENABLE;
        wr_en      = access & apb.PWRITE & ~err;
    end

    // Per-register write strobes; an errored access produces none.
    always_comb begin
        wr_ctrl   = wr_en && is_glb && (reg_sel == 2'd0);
        wr_status = wr_en && is_glb && (reg_sel == 2'd1);
        wr_irq_en = wr_en && is_glb && (reg_sel == 2'd2);
        wr_per    = '0;
        wr_duty   = '0;
        wr_cfg    = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (wr_en && ch_ok && (ch_idx == 4'(n))) begin
                case (reg_sel)
                    2'd0:    wr_per[n]  = 1'b1;
                    2'd1:    wr_duty[n] = 1'b1;
                    2'd2:    wr_cfg[n]  = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Compute run state now and after this edge. run 0->1 between them is an activation.
    always_comb begin
        gen_d = wr_ctrl ? apb.PWDATA[0] : gen_q;
        for (int n = 0; n < NUM_CH; n++) begin
            en_d[n]  = wr_cfg[n] ? apb.PWDATA[0] : en_q[n];
            run_q[n] = gen_q & en_q[n];
            run_d[n] = gen_d & en_d[n];
            wrap[n]  = run_q[n] && (cnt_q[n] == per_act_q[n]);
        end
    end

    // Read mux; zero outside a valid read access phase.
    always_comb begin
        rdata = '0;
        if (access && !apb.PWRITE && !err) begin
            if (is_glb) begin
                case (reg_sel)
                    2'd0:    rdata = DATA_W'(gen_q);
                    2'd1:    rdata = DATA_W'(status_q);
                    2'd2:    rdata = DATA_W'(irq_en_q);
                    default: ;
                endcase
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (ch_ok && (ch_idx == 4'(n))) begin
                    case (reg_sel)
                        2'd0:    rdata = DATA_W'(period_q[n]);
                        2'd1:    rdata = DATA_W'(duty_q[n]);
                        2'd2:    rdata = DATA_W'({pol_q[n], en_q[n]});
                        default: rdata = DATA_W'(cnt_q[n]);
                    endcase
                end
            end
        end
    end

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = access & err;
    assign apb.PRDATA  = rdata;
    assign pwm_out     = pwm_q;
    assign irq         = irq_q;

    // Global registers. On the same edge, a wrap overrides a W1C clear.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            gen_q    <= 1'b0;
            irq_en_q <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            gen_q <= gen_d;
            if (wr_irq_en) irq_en_q <= apb.PWDATA[NUM_CH-1:0];
            status_q <= (status_q & ~(wr_status ? apb.PWDATA[NUM_CH-1:0] : '0)) | wrap;
            irq_q    <= |(status_q & irq_en_q);
        end
    end

    // Per-channel configuration, counter, shadow transfer and registered output.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            en_q  <= '0;
            pol_q <= '0;
            pwm_q <= '0;
            for (int n = 0; n < NUM_CH; n++) begin
                period_q[n]   <= '0;
                duty_q[n]     <= '0;
                cnt_q[n]      <= '0;
                per_act_q[n]  <= '0;
                duty_act_q[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (wr_per[n])  period_q[n] <= apb.PWDATA[CNT_W-1:0];
                if (wr_duty[n]) duty_q[n]   <= apb.PWDATA[CNT_W-1:0];
                en_q[n] <= en_d[n];
                if (wr_cfg[n])  pol_q[n]    <= apb.PWDATA[1];
                if (run_q[n]) begin
                    pwm_q[n] <= (cnt_q[n] < duty_act_q[n]) ^ pol_q[n];
                    if (wrap[n]) begin
                        cnt_q[n]      <= '0;
                        per_act_q[n]  <= period_q[n];
                        duty_act_q[n] <= duty_q[n];
                    end else begin
                        cnt_q[n] <= cnt_q[n] + CNT_W'(1);
                    end
                end else begin
                    cnt_q[n] <= '0;
                    pwm_q[n] <= pol_q[n];
                    if (run_d[n]) begin
                        per_act_q[n]  <= period_q[n];
                        duty_act_q[n] <= duty_q[n];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_pwm_multi.sv
// Testbench for apb_pwm_multi. Uses directed and randomized APB traffic against a per-cycle
// reference model of the channel rules.
module tb_apb_pwm_multi;

    localparam int NCH = 4;

    logic           PCLK = 1'b0;
    logic           PRESETn = 1'b0;
    logic [NCH-1:0] pwm_out;
    logic           irq;

    apb_pwm_multi_if #(.ADDR_W(12), .DATA_W(32)) bus ();

    apb_pwm_multi #(.NUM_CH(NCH), .CNT_W(16), .ADDR_W(12), .DATA_W(32)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .apb     (bus),
        .pwm_out (pwm_out),
        .irq     (irq)
    );

    always #5 PCLK = ~PCLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    bit           m_gen, m_irq;
    bit [NCH-1:0] m_status, m_irq_en, m_en, m_pol, m_pwm;
    int           m_period[NCH], m_duty[NCH], m_cnt[NCH], m_pact[NCH], m_dact[NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_err(input int addr, input bit wr);
        int ch, r;
        if (addr % 4 != 0) return 1'b1;
        if (addr < 'h100) return !(addr == 0 || addr == 4 || addr == 8);
        if (addr < 'h200) begin
            ch = (addr - 'h100) / 16;
            r  = (addr % 16) / 4;
            if (ch >= NCH) return 1'b1;
            return (r == 3) && wr;
        end
        return 1'b1;
    endfunction

    function automatic int m_read(input int addr);
        int ch, r;
        if (m_err(addr, 1'b0)) return 0;
        if (addr == 0) return int'(m_gen);
        if (addr == 4) return int'(m_status);
        if (addr == 8) return int'(m_irq_en);
        ch = (addr - 'h100) / 16;
        r  = (addr % 16) / 4;
        case (r)
            0:       return m_period[ch];
            1:       return m_duty[ch];
            2:       return int'({m_pol[ch], m_en[ch]});
            default: return m_cnt[ch];
        endcase
    endfunction

    task automatic model_reset();
        m_gen = 0; m_irq = 0; m_status = '0; m_irq_en = '0; m_en = '0; m_pol = '0; m_pwm = '0;
        for (int i = 0; i < NCH; i++) begin
            m_period[i] = 0; m_duty[i] = 0; m_cnt[i] = 0; m_pact[i] = 0; m_dact[i] = 0;
        end
    endtask

    // One rising edge: register writes commit, channels advance from pre-edge values.
    task automatic model_step();
        bit           n_gen;
        bit [NCH-1:0] n_irq_en, n_en, n_pol, clr, wraps;
        int           n_period[NCH], n_duty[NCH];
        int           a, d, ch, r;
        if (!PRESETn) begin
            model_reset();
            return;
        end
        n_gen = m_gen; n_irq_en = m_irq_en; n_en = m_en; n_pol = m_pol; clr = '0; wraps = '0;
        n_period = m_period; n_duty = m_duty;
        a = int'(bus.PADDR);
        d = int'(bus.PWDATA);
        if (bus.PSEL && bus.PENABLE && bus.PWRITE && !m_err(a, 1'b1)) begin
            if (a == 0) n_gen = d[0];
            else if (a == 4) clr = NCH'(d);
            else if (a == 8) n_irq_en = NCH'(d);
            else begin
                ch = (a - 'h100) / 16;
                r  = (a % 16) / 4;
                if (r == 0) n_period[ch] = d & 'hFFFF;
                if (r == 1) n_duty[ch] = d & 'hFFFF;
                if (r == 2) begin n_en[ch] = d[0]; n_pol[ch] = d[1]; end
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (m_gen && m_en[i]) begin
                m_pwm[i] = (m_cnt[i] < m_dact[i]) ^ m_pol[i];
                if (m_cnt[i] == m_pact[i]) begin
                    m_cnt[i] = 0; m_pact[i] = m_period[i]; m_dact[i] = m_duty[i]; wraps[i] = 1'b1;
                end else begin
                    m_cnt[i]++;
                end
            end else begin
                m_cnt[i] = 0;
                m_pwm[i] = m_pol[i];
                if (n_gen && n_en[i]) begin
                    m_pact[i] = m_period[i]; m_dact[i] = m_duty[i];
                end
            end
        end
        m_irq    = |(m_status & m_irq_en);
        m_status = (m_status & ~clr) | wraps;
        m_gen = n_gen; m_irq_en = n_irq_en; m_en = n_en; m_pol = n_pol;
        m_period = n_period; m_duty = n_duty;
    endtask

    task automatic tick();
        @(posedge PCLK);
        model_step();
        #1;
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic apb(input bit wr, input int addr, input int data, output int rd);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
        bus.PADDR = 12'(addr); bus.PWDATA = data;
        tick();
        bus.PENABLE = 1'b1;
        #1;
        check($sformatf("pslverr@%0h", addr), 32'(bus.PSLVERR), 32'(m_err(addr, wr)));
        check("pready", 32'(bus.PREADY), 32'd1);
        if (!wr) check($sformatf("prdata@%0h", addr), bus.PRDATA, m_read(addr));
        rd = int'(bus.PRDATA);
        tick();
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic apb_wr(input int addr, input int data);
        int unused;
        apb(1'b1, addr, data, unused);
    endtask

    task automatic apb_rd(input int addr, output int rd);
        apb(1'b0, addr, 0, rd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // High cycles of one channel over a window; for a periodic wave, any full-period window
    // counts exactly the duty.
    task automatic highs(input int ch, input int n, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (pwm_out[ch]) h++;
        end
    endtask

    task automatic wait_cnt(input int ch, input int val);
        int k = 0;
        while (m_cnt[ch] != val && k < 40) begin tick(); k++; end
        if (k == 40) begin
            miscompares++;
            $error("FAIL wait_cnt: observed timeout expected cnt %0d", val);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1);
    end

    initial begin
        int rd, h, first;
        int addrs[$];
        bus.PSEL = 0; bus.PENABLE = 0; bus.PWRITE = 0; bus.PADDR = '0; bus.PWDATA = '0;
        model_reset();
        #3;
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
        #9 PRESETn = 1'b1;

        // Reset read-back of every register
        apb_rd('h0, rd); apb_rd('h4, rd); apb_rd('h8, rd);
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++) begin
                apb_rd('h100 + c * 16 + r * 4, rd);
                check("rst_read", rd, 0);
            end

        // All-ones write, truncated to implemented bits
        apb_wr('h100, 'hFFFFFFFF); apb_wr('h104, 'hFFFFFFFF); apb_wr('h108, 'hFFFFFFFF);
        apb_rd('h100, rd); check("rb_period", rd, 'hFFFF);
        apb_rd('h104, rd); check("rb_duty", rd, 'hFFFF);
        apb_rd('h108, rd); check("rb_cfg", rd, 'h3);
        apb_wr('h108, 0);

        // Basic waveform on ch1: period 10, 3 high
        apb_wr('h110, 9); apb_wr('h114, 3); apb_wr('h118, 1); apb_wr('h8, 2);
        apb_wr('h0, 1);
        first = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (irq && first == 0) first = i;
        end
        check("irq_first_wrap", first, 11);
        idle(10);
        highs(1, 10, h); check("duty3_highs", h, 3);

        // Shadow update mid-period
        wait_cnt(1, 2);
        apb_wr('h114, 7);
        idle(25);
        highs(1, 10, h); check("duty7_highs", h, 7);

        // DUTY written on the exact wrap edge waits a full period
        wait_cnt(1, 8);
        apb_wr('h114, 2);
        highs(1, 10, h); check("wrap_edge_old", h, 7);
        highs(1, 10, h); check("wrap_edge_new", h, 2);

        // Edge duty values and polarity
        apb_wr('h114, 0);  idle(25); highs(1, 10, h); check("duty0", h, 0);
        apb_wr('h114, 12); idle(25); highs(1, 10, h); check("duty_over", h, 10);
        apb_wr('h118, 3);  idle(3);  highs(1, 10, h); check("pol_inv", h, 0);
        apb_wr('h118, 2);  idle(3);  check("idle_pol", 32'(pwm_out[1]), 32'd1);

        // Error responses: no state change, reads return 0
        apb_rd('h040, rd);  check("err_rd_040", rd, 0);
        apb_wr('h040, 1);
        apb_rd('h140, rd);  check("err_rd_ch4", rd, 0);
        apb_wr('h140, 5);
        apb_wr('h10C, 5);
        apb_rd('h102, rd);  check("err_rd_mis", rd, 0);
        apb_wr('h102, 3);
        apb_rd('h100, rd);  check("err_nochange", rd, 'hFFFF);

        // Randomized traffic across the map
        addrs = {0, 4, 8, 'h040, 'h140, 'h102};
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++) addrs.push_back('h100 + c * 16 + r * 4);
        for (int t = 0; t < 150; t++) begin
            int a, d;
            a = addrs[$urandom_range(0, addrs.size() - 1)];
            if (a == 0) d = int'($urandom_range(0, 3) != 0);
            else if ((a % 16 == 0 || a % 16 == 4) && a >= 'h100) d = $urandom_range(0, 12);
            else d = $urandom;
            if ($urandom_range(0, 1) == 1) apb_wr(a, d);
            else apb_rd(a, rd);
            idle($urandom_range(0, 3));
        end

        // W1C colliding with a wrap: ch2 wraps every cycle with period 0
        apb_wr('h120, 0); apb_wr('h128, 1); apb_wr('h0, 1);
        idle(20);
        apb_wr('h4, 'hF);
        apb_rd('h4, rd); check("w1c_collision", (rd >> 2) & 1, 1);

        // Asynchronous reset mid-period
        apb_wr('h130, 100); apb_wr('h138, 1); apb_wr('h108, 2); apb_wr('h8, 'hF);
        idle(30);
        #2 PRESETn = 1'b0;
        #1;
        model_reset();
        check("arst_pwm", 32'(pwm_out), 32'd0);
        check("arst_irq", 32'(irq), 32'd0);
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = 12'h13C;
        #1 check("arst_cnt", bus.PRDATA, 0);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        #1 PRESETn = 1'b1;
        tick();
        apb_rd('h0, rd);   check("post_rst_gen", rd, 0);
        apb_rd('h13C, rd); check("post_rst_cnt", rd, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
